// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        RUN  = 2'd2
    } chan_state_e;

    // ceil(n/2): high-phase length for the default ~50% duty; n up to 32 bits.
    function automatic logic [31:0] ceil_half(input logic [31:0] n);
        return (n >> 1) + {31'd0, n[0]};
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadowed divisor, state machine, period counter, registered outputs.
// Optional per-channel duty register when CLK_DIV_DUTY_EN is defined.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic             sync,
    input  logic [WIDTH-1:0] divisor,
`ifdef CLK_DIV_DUTY_EN
    input  logic [WIDTH-1:0] duty,
`endif
    output logic             div,
    output logic             tick,
    output logic             active
);

    chan_state_e      state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] act_n, n_nxt, pend_n, pend_n_nxt;
    logic             pend_vld, vld_nxt;
    logic             xfer, wrap;
    logic             div_nxt, tick_nxt;
    logic [31:0]      hlim;
`ifdef CLK_DIV_DUTY_EN
    logic [WIDTH-1:0] act_d, d_nxt, pend_d, pend_d_nxt;
`endif

    always_comb begin
        wrap       = (state == RUN) && (cnt == act_n - WIDTH'(1));
        // Pending only lands on a period boundary, a resync, or when not counting.
        xfer       = pend_vld && ((state != RUN) || wrap || sync);
        n_nxt      = act_n;
        pend_n_nxt = pend_n;
        vld_nxt    = pend_vld;
`ifdef CLK_DIV_DUTY_EN
        d_nxt      = act_d;
        pend_d_nxt = pend_d;
`endif
        if (load && sync) begin
            n_nxt   = divisor;
            vld_nxt = 1'b0;
`ifdef CLK_DIV_DUTY_EN
            d_nxt   = duty;
`endif
        end else begin
            if (xfer) begin
                n_nxt   = pend_n;
                vld_nxt = 1'b0;
`ifdef CLK_DIV_DUTY_EN
                d_nxt   = pend_d;
`endif
            end
            if (load) begin
                pend_n_nxt = divisor;
                vld_nxt    = 1'b1;
`ifdef CLK_DIV_DUTY_EN
                pend_d_nxt = duty;
`endif
            end
        end

        if (!enable || n_nxt == '0)  state_nxt = IDLE;
        else if (n_nxt == WIDTH'(1)) state_nxt = PASS;
        else                         state_nxt = RUN;

        if (state_nxt != RUN || state != RUN || sync || wrap) cnt_nxt = '0;
        else                                                   cnt_nxt = cnt + WIDTH'(1);

`ifdef CLK_DIV_DUTY_EN
        // cnt never reaches N, so D >= N naturally holds the output high.
        hlim = 32'(d_nxt);
`else
        hlim = ceil_half(32'(n_nxt));
`endif
        div_nxt  = (state_nxt == RUN) && (32'(cnt_nxt) < hlim);
        tick_nxt = (state_nxt == PASS) ||
                   ((state_nxt == RUN) && (cnt_nxt == n_nxt - WIDTH'(1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            act_n    <= '0;
            pend_n   <= '0;
            pend_vld <= 1'b0;
            div      <= 1'b0;
            tick     <= 1'b0;
`ifdef CLK_DIV_DUTY_EN
            act_d    <= '0;
            pend_d   <= '0;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            act_n    <= n_nxt;
            pend_n   <= pend_n_nxt;
            pend_vld <= vld_nxt;
            div      <= div_nxt;
            tick     <= tick_nxt;
`ifdef CLK_DIV_DUTY_EN
            act_d    <= d_nxt;
            pend_d   <= pend_d_nxt;
`endif
        end
    end

    assign active = (state != IDLE);

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider with double-buffered divisors and phase-align strobe.
// Define CLK_DIV_DUTY_EN to add the per-channel i_duty input.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CHANNELS-1:0]       i_enable,
    input  logic [CHANNELS-1:0]       i_load,
    input  logic [CHANNELS*WIDTH-1:0] i_divisor,
`ifdef CLK_DIV_DUTY_EN
    input  logic [CHANNELS*WIDTH-1:0] i_duty,
`endif
    input  logic                      i_sync,
    output logic [CHANNELS-1:0]       o_div,
    output logic [CHANNELS-1:0]       o_tick,
    output logic [CHANNELS-1:0]       o_active
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        clk_div_chan #(.WIDTH(WIDTH)) u_chan (
            .clk     (i_clk),
            .rst     (i_rst),
            .enable  (i_enable[c]),
            .load    (i_load[c]),
            .sync    (i_sync),
            .divisor (i_divisor[c*WIDTH +: WIDTH]),
`ifdef CLK_DIV_DUTY_EN
            .duty    (i_duty[c*WIDTH +: WIDTH]),
`endif
            .div     (o_div[c]),
            .tick    (o_tick[c]),
            .active  (o_active[c])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: per-cycle expected outputs are queued as stimulus is driven.
module tb_clk_div_multi;
    localparam int CH = 4;
    localparam int W  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   en, ld;
    logic [CH*W-1:0] dv;
`ifdef CLK_DIV_DUTY_EN
    logic [CH*W-1:0] dt;
`endif
    logic            sync;
    logic [CH-1:0]   odiv, otick, oact;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string         tag;
        logic [CH-1:0] m, d, t, a;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    clk_div_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_enable  (en),
        .i_load    (ld),
        .i_divisor (dv),
`ifdef CLK_DIV_DUTY_EN
        .i_duty    (dt),
`endif
        .i_sync    (sync),
        .o_div     (odiv),
        .o_tick    (otick),
        .o_active  (oact)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Queue the expectation for the coming edge, clock it, then pop and compare masked channels.
    task automatic step(input string tag, input logic [CH-1:0] m, input logic [CH-1:0] d,
                        input logic [CH-1:0] t, input logic [CH-1:0] a);
        exp_t e;
        e.tag = tag; e.m = m; e.d = d; e.t = t; e.a = a;
        sbq.push_back(e);
        @(posedge clk); #1;
        e = sbq.pop_front();
        if (e.m != '0) begin
            chk({e.tag, ".div"},    32'(odiv  & e.m), 32'(e.d & e.m));
            chk({e.tag, ".tick"},   32'(otick & e.m), 32'(e.t & e.m));
            chk({e.tag, ".active"}, 32'(oact  & e.m), 32'(e.a & e.m));
        end
    endtask

    task automatic set_ld(input int c, input int n, input int d);
        ld[c] = 1'b1;
        dv[c*W +: W] = W'(n);
`ifdef CLK_DIV_DUTY_EN
        dt[c*W +: W] = W'(d);
`else
        if (d < 0) $display("negative duty ignored");
`endif
    endtask

    // Single running channel c, divisor n, high length h, starting at count k0.
    task automatic run(input string tag, input int c, input int n, input int h,
                       input int k0, input int cycles);
        logic [CH-1:0] b, d, t;
        for (int i = 0; i < cycles; i++) begin
            int k;
            k = (k0 + i) % n;
            b = '0; b[c] = 1'b1;
            d = (k < h)      ? b : '0;
            t = (k == n - 1) ? b : '0;
            step(tag, b, d, t, b);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = '0; ld = '0; dv = '0; sync = 1'b0;
`ifdef CLK_DIV_DUTY_EN
        dt = '0;
`endif
        step("reset", '1, '0, '0, '0);
        step("reset", '1, '0, '0, '0);
        rst = 1'b0;

        // ch0 N=3
        en[0] = 1'b1; set_ld(0, 3, 2);
        step("t1_ld", 4'b0001, '0, '0, '0);
        ld = '0;
        run("t1_n3", 0, 3, 2, 0, 9);

        // ch1 N=4, reload N=6 while cnt=1: 4-cycle period completes first
        en[1] = 1'b1; set_ld(1, 4, 2);
        step("t2_ld", 4'b0010, '0, '0, '0);
        ld = '0;
        run("t2_n4a", 1, 4, 2, 0, 2);
        set_ld(1, 6, 3);
        run("t2_n4b", 1, 4, 2, 2, 1);
        ld = '0;
        run("t2_n4c", 1, 4, 2, 3, 1);
        run("t2_n6", 1, 6, 3, 0, 12);

        // ch2 PASS then back to IDLE via N=0
        en[2] = 1'b1; set_ld(2, 1, 1);
        step("t3_ld", 4'b0100, '0, '0, '0);
        ld = '0;
        repeat (4) step("t3_pass", 4'b0100, '0, 4'b0100, 4'b0100);
        set_ld(2, 0, 0);
        step("t3_ld0", 4'b0100, '0, 4'b0100, 4'b0100);
        ld = '0;
        repeat (2) step("t3_idle", 4'b0100, '0, '0, '0);

        // ch0 N=5 and ch3 N=7, then sync: ticks coincide every 35 cycles
        set_ld(0, 5, 3); en[3] = 1'b1; set_ld(3, 7, 4);
        step("t4_ld", '0, '0, '0, '0);
        ld = '0;
        repeat (10) step("t4_settle", '0, '0, '0, '0);
        sync = 1'b1;
        step("t4_sync", 4'b1001, 4'b1001, '0, 4'b1001);
        sync = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            logic [CH-1:0] d, t;
            d = '0; t = '0;
            d[0] = (k % 5) < 3;  t[0] = (k % 5) == 4;
            d[3] = (k % 7) < 4;  t[3] = (k % 7) == 6;
            step("t4_align", 4'b1001, d, t, 4'b1001);
        end
        set_ld(3, 4, 2); sync = 1'b1;
        step("t4_ldsync", 4'b1000, 4'b1000, '0, 4'b1000);
        ld = '0; sync = 1'b0;
        run("t4_n4", 3, 4, 2, 1, 7);

        // ch1 N=9, reset at cnt=4, stays idle until reloaded
        set_ld(1, 9, 5); sync = 1'b1;
        step("t5_n9", 4'b0010, 4'b0010, '0, 4'b0010);
        ld = '0; sync = 1'b0;
        run("t5_n9", 1, 9, 5, 1, 4);
        rst = 1'b1;
        step("t5_rst", '1, '0, '0, '0);
        rst = 1'b0;
        repeat (3) step("t5_idle", '1, '0, '0, '0);
        set_ld(1, 2, 1);
        step("t5_ld", 4'b0010, '0, '0, '0);
        ld = '0;
        run("t5_n2", 1, 2, 1, 0, 4);
        en[1] = 1'b0;
        step("t5_dis", 4'b0010, '0, '0, '0);

`ifdef CLK_DIV_DUTY_EN
        set_ld(2, 10, 3); sync = 1'b1;
        run("td_d3", 2, 10, 3, 0, 1);
        ld = '0; sync = 1'b0;
        run("td_d3", 2, 10, 3, 1, 19);
        set_ld(2, 10, 12); sync = 1'b1;
        run("td_d12", 2, 10, 12, 0, 1);
        ld = '0; sync = 1'b0;
        run("td_d12", 2, 10, 12, 1, 19);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
